// File: rtl/multi_cycle_core_pkg.sv
// Shared ISA constants, FSM state and ALU-op encodings, plus small decode/ALU helpers
// for the multi-cycle MIPS-subset core.
package multi_cycle_core_pkg;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;

   localparam logic [5:0] FnAdd = 6'h20;
   localparam logic [5:0] FnSub = 6'h22;
   localparam logic [5:0] FnAnd = 6'h24;
   localparam logic [5:0] FnOr  = 6'h25;
   localparam logic [5:0] FnSlt = 6'h2A;

   typedef enum logic [2:0] {
      StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
   } state_e;

   typedef enum logic [2:0] {
      AluAdd, AluSub, AluAnd, AluOr, AluSlt
   } alu_op_e;

   function automatic logic is_legal(logic [5:0] op, logic [5:0] fn);
      case (op)
         OpRtype:                     return fn inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt};
         OpAddi, OpLw, OpSw, OpBeq, OpJ: return 1'b1;
         default:                     return 1'b0;
      endcase
   endfunction

   // Non-R opcodes that reach the ALU (addi, lw, sw) all add.
   function automatic alu_op_e decode_alu(logic [5:0] op, logic [5:0] fn);
      if (op != OpRtype) return AluAdd;
      case (fn)
         FnSub:   return AluSub;
         FnAnd:   return AluAnd;
         FnOr:    return AluOr;
         FnSlt:   return AluSlt;
         default: return AluAdd;
      endcase
   endfunction

   function automatic logic [31:0] alu_calc(alu_op_e op, logic [31:0] a, logic [31:0] b);
      case (op)
         AluSub:  return a - b;
         AluAnd:  return a & b;
         AluOr:   return a | b;
         AluSlt:  return {31'b0, $signed(a) < $signed(b)};
         default: return a + b;
      endcase
   endfunction

endpackage

// File: rtl/multi_cycle_core_if.sv
// Shared instruction/data memory port with a req/ack handshake.
interface multi_cycle_core_if #(
   parameter int unsigned PC_W = 9
) ();
   logic            req;
   logic            we;
   logic [PC_W-1:0] addr;
   logic [31:0]     wdata;
   logic [31:0]     rdata;
   logic            ack;

   modport master (output req, we, addr, wdata, input rdata, ack);
   modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mc_regfile.sv
// 32x32 GPR file: two async operand reads, one async debug read, one sync write.
// Register 0 is never written, so it always reads zero.
module mc_regfile (
   input  logic        clock_i,
   input  logic        reset_ni,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_a_i,
   input  logic [4:0]  raddr_b_i,
   input  logic [4:0]  raddr_d_i,
   output logic [31:0] rdata_a_o,
   output logic [31:0] rdata_b_o,
   output logic [31:0] rdata_d_o
);
   logic [31:0] regs_q [32];

   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we_i && (waddr_i != 5'd0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = regs_q[raddr_a_i];
   assign rdata_b_o = regs_q[raddr_b_i];
   assign rdata_d_o = regs_q[raddr_d_i];
endmodule

// File: rtl/multi_cycle_core.sv
// Multi-cycle MIPS-subset core: one shared memory port, run/single-step control,
// sticky halt on illegal instructions, retire and cycle counters.
module multi_cycle_core
   import multi_cycle_core_pkg::*;
#(
   parameter int unsigned PC_W     = 9,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned RESET_PC = 0
) (
   input  logic               clock_i,
   input  logic               reset_ni,
   input  logic               run_en_i,
   input  logic               step_i,
   multi_cycle_core_if.master mem,
   input  logic [4:0]         test_addr_i,
   output logic [31:0]        test_out_o,
   output logic [PC_W-1:0]    pc_out_o,
   output logic               retire_o,
   output logic               halted_o,
   output logic               busy_o,
   output logic [CNT_W-1:0]   cycle_count_o,
   output logic [CNT_W-1:0]   instr_count_o
);
   state_e           state_q;
   logic [PC_W-1:0]  pc_q, mem_addr_q;
   logic [31:0]      ir_q, a_q, b_q, alu_q, mdr_q, mem_wdata_q;
   logic             mem_req_q, mem_we_q, retire_q, halted_q, step_q;
   logic [CNT_W-1:0] cyc_q, icnt_q;

   logic [5:0]      opcode, funct;
   logic [4:0]      rs, rt, rd;
   logic [31:0]     imm_sext, alu_b, alu_res, rf_a, rf_b, rf_wdata;
   logic [4:0]      rf_waddr;
   logic            rf_we, ack_ok, start, br_taken, retire_now;
   logic [PC_W-1:0] ret_pc;

   always_comb begin
      opcode   = ir_q[31:26];
      funct    = ir_q[5:0];
      rs       = ir_q[25:21];
      rt       = ir_q[20:16];
      rd       = ir_q[15:11];
      imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
      alu_b    = (opcode == OpRtype) ? b_q : imm_sext;
      alu_res  = alu_calc(decode_alu(opcode, funct), a_q, alu_b);
      ack_ok   = mem_req_q & mem.ack;
      start    = run_en_i | (step_i & ~step_q);
      br_taken = (opcode == OpBeq) && (a_q == b_q);
      // PC of the next fetch when this cycle retires; only a taken beq moves it here.
      ret_pc   = br_taken ? pc_q + PC_W'({imm_sext[29:0], 2'b00}) : pc_q;
      retire_now = ((state_q == StExec) && ((opcode == OpBeq) || (opcode == OpJ))) ||
                   ((state_q == StMem) && ack_ok && mem_we_q) ||
                   (state_q == StWb);
      rf_we    = (state_q == StWb);
      rf_waddr = (opcode == OpRtype) ? rd : rt;
      rf_wdata = (opcode == OpLw) ? mdr_q : alu_q;
   end

   mc_regfile u_regfile (
      .clock_i   (clock_i),
      .reset_ni  (reset_ni),
      .we_i      (rf_we),
      .waddr_i   (rf_waddr),
      .wdata_i   (rf_wdata),
      .raddr_a_i (rs),
      .raddr_b_i (rt),
      .raddr_d_i (test_addr_i),
      .rdata_a_o (rf_a),
      .rdata_b_o (rf_b),
      .rdata_d_o (test_out_o)
   );

   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         state_q     <= StIdle;
         pc_q        <= PC_W'(RESET_PC);
         ir_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         alu_q       <= '0;
         mdr_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         retire_q    <= 1'b0;
         halted_q    <= 1'b0;
         step_q      <= 1'b0;
         cyc_q       <= '0;
         icnt_q      <= '0;
      end else begin
         step_q   <= step_i;
         retire_q <= 1'b0;
         if (!halted_q) cyc_q <= cyc_q + CNT_W'(1);

         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q    <= StFetch;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= pc_q;
               end
            end
            StFetch: begin
               if (ack_ok) begin
                  ir_q      <= mem.rdata;
                  pc_q      <= pc_q + PC_W'(4);
                  mem_req_q <= 1'b0;
                  state_q   <= StDecode;
               end
            end
            StDecode: begin
               a_q <= rf_a;
               b_q <= rf_b;
               if (!is_legal(opcode, funct)) begin
                  state_q  <= StHalt;
                  halted_q <= 1'b1;
                  pc_q     <= pc_q - PC_W'(4);
               end else begin
                  state_q <= StExec;
                  if (opcode == OpJ) pc_q <= PC_W'({ir_q[25:0], 2'b00});
               end
            end
            StExec: begin
               alu_q <= alu_res;
               if ((opcode == OpLw) || (opcode == OpSw)) begin
                  state_q     <= StMem;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= (opcode == OpSw);
                  mem_addr_q  <= PC_W'(alu_res);
                  mem_wdata_q <= b_q;
               end else if ((opcode == OpBeq) || (opcode == OpJ)) begin
                  pc_q <= ret_pc;
               end else begin
                  state_q <= StWb;
               end
            end
            StMem: begin
               if (ack_ok) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  if (!mem_we_q) begin
                     mdr_q   <= mem.rdata;
                     state_q <= StWb;
                  end
               end
            end
            StWb, StHalt: ;
            default: state_q <= StIdle;
         endcase

         // In run mode a retiring instruction chains straight into the next fetch.
         if (retire_now) begin
            retire_q <= 1'b1;
            icnt_q   <= icnt_q + CNT_W'(1);
            if (run_en_i) begin
               state_q    <= StFetch;
               mem_req_q  <= 1'b1;
               mem_we_q   <= 1'b0;
               mem_addr_q <= ret_pc;
            end else begin
               state_q <= StIdle;
            end
         end
      end
   end

   assign mem.req       = mem_req_q;
   assign mem.we        = mem_we_q;
   assign mem.addr      = mem_addr_q;
   assign mem.wdata     = mem_wdata_q;
   assign pc_out_o      = pc_q;
   assign retire_o      = retire_q;
   assign halted_o      = halted_q;
   assign busy_o        = !(state_q inside {StIdle, StHalt});
   assign cycle_count_o = cyc_q;
   assign instr_count_o = icnt_q;
endmodule
